// File: rtl/lc4_wb_pkg.sv
// Shared constants and state encoding for the LC4 writeback arbiter.
package lc4_wb_pkg;
  localparam int   REG_SEL_W = 3;
  localparam int   NUM_REGS  = 8;
  localparam logic REQ_A     = 1'b0;
  localparam logic REQ_B     = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stg_state_e;
endpackage

// File: rtl/lc4_rr_arb2.sv
// Two-way round-robin arbiter: the pointer only moves on a genuine conflict,
// so a lone requester never steals the other's next turn.
module lc4_rr_arb2
  import lc4_wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic ptr;
  logic conflict;

  assign conflict = req_a & req_b;
  assign gnt_a    = en & req_a & (~req_b | (ptr == REQ_A));
  assign gnt_b    = en & req_b & (~req_a | (ptr == REQ_B));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ptr <= REQ_A;
    else if (en & conflict) ptr <= ~ptr;
  end
endmodule

// File: rtl/lc4_wb_arbiter.sv
// Writeback arbiter: merges ALU (A) and load (B) writebacks into one staged
// regfile write per cycle. Define LC4_WB_FWD_EN to build the forwarding lookup.
module lc4_wb_arbiter
  import lc4_wb_pkg::*;
#(
  parameter int n = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 i_a_valid,
  input  logic [REG_SEL_W-1:0] i_a_rd,
  input  logic [n-1:0]         i_a_wdata,
  output logic                 o_a_ready,
  input  logic                 i_b_valid,
  input  logic [REG_SEL_W-1:0] i_b_rd,
  input  logic [n-1:0]         i_b_wdata,
  output logic                 o_b_ready,
  output logic [REG_SEL_W-1:0] o_rd,
  output logic [n-1:0]         o_wdata,
  output logic                 o_rd_we,
  output logic                 o_last_b,
  input  logic [REG_SEL_W-1:0] i_rs,
  input  logic [REG_SEL_W-1:0] i_rt,
  output logic                 o_rs_hit,
  output logic                 o_rt_hit,
  output logic [n-1:0]         o_rs_fwd,
  output logic [n-1:0]         o_rt_fwd
);
  stg_state_e state, state_nxt;
  logic       en, gnt_a, gnt_b;

  // rst gates the grants so readies drop the instant reset asserts.
  assign en = gwe & ~rst;

  lc4_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req_a (i_a_valid),
    .req_b (i_b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign o_a_ready = gnt_a;
  assign o_b_ready = gnt_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Any gwe edge drains the current entry; it refills only if someone was granted.
  always_comb begin
    state_nxt = state;
    if (gwe) state_nxt = (gnt_a | gnt_b) ? FULL : EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd     <= '0;
      o_wdata  <= '0;
      o_last_b <= 1'b0;
    end else if (gnt_a) begin
      o_rd     <= i_a_rd;
      o_wdata  <= i_a_wdata;
      o_last_b <= 1'b0;
    end else if (gnt_b) begin
      o_rd     <= i_b_rd;
      o_wdata  <= i_b_wdata;
      o_last_b <= 1'b1;
    end
  end

  assign o_rd_we = (state == FULL);

`ifdef LC4_WB_FWD_EN
  assign o_rs_hit = o_rd_we & (i_rs == o_rd);
  assign o_rt_hit = o_rd_we & (i_rt == o_rd);
  assign o_rs_fwd = o_wdata;
  assign o_rt_fwd = o_wdata;
`else
  logic unused_sel;
  assign unused_sel = ^{i_rs, i_rt};
  assign o_rs_hit   = 1'b0;
  assign o_rt_hit   = 1'b0;
  assign o_rs_fwd   = '0;
  assign o_rt_fwd   = '0;
`endif
endmodule

// File: tb/tb_lc4_wb_arbiter.sv
// Directed bench for lc4_wb_arbiter; a shadow register file captures commits.
module tb_lc4_wb_arbiter;
  import lc4_wb_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, gwe;
  logic                 a_valid, b_valid, a_ready, b_ready;
  logic [REG_SEL_W-1:0] a_rd, b_rd, rd, rs, rt;
  logic [15:0]          a_wdata, b_wdata, wdata, rs_fwd, rt_fwd;
  logic                 rd_we, last_b, rs_hit, rt_hit;

  logic [15:0] rf [NUM_REGS] = '{default: '0};
  int          ncommit = 0;
  int          ntests  = 0;
  int          nfail   = 0;
  int          c0;

  lc4_wb_arbiter #(.n(16)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_wdata(a_wdata), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_wdata(b_wdata), .o_b_ready(b_ready),
    .o_rd(rd), .o_wdata(wdata), .o_rd_we(rd_we), .o_last_b(last_b),
    .i_rs(rs), .i_rt(rt), .o_rs_hit(rs_hit), .o_rt_hit(rt_hit),
    .o_rs_fwd(rs_fwd), .o_rt_fwd(rt_fwd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && gwe && rd_we) begin
      rf[rd]  <= wdata;
      ncommit <= ncommit + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; gwe = 1'b1;
    a_valid = 1'b1; a_rd = 3'd3; a_wdata = 16'h5555;
    b_valid = 1'b1; b_rd = 3'd4; b_wdata = 16'h6666;
    rs = 3'd0; rt = 3'd0;
    #3;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_we", rd_we, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_last_b", last_b, 0);
    chk("rst_rs_hit", rs_hit, 0);
    repeat (2) cyc();
    chk("rst_edges_we", rd_we, 0);

    // Single write after reset
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
    #1;
    a_valid = 1'b1; a_rd = 3'd3; a_wdata = 16'h1234;
    #1;
    chk("a_only_ready", a_ready, 1);
    chk("a_only_b_ready", b_ready, 0);
    cyc();
    a_valid = 1'b0;
    chk("a_only_rd", rd, 3);
    chk("a_only_wdata", wdata, 16'h1234);
    chk("a_only_we", rd_we, 1);
    chk("a_only_last_b", last_b, 0);
    cyc();
    chk("idle_empty_we", rd_we, 0);
    chk("a_only_commit", rf[3], 16'h1234);

    // Continuous conflict: A,B,A,B
    c0 = ncommit;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rd = 3'd1; a_wdata = 16'h1000 + 16'((i + 1) / 2);
      b_valid = 1'b1; b_rd = 3'd2; b_wdata = 16'h2000 + 16'(i / 2);
      #1;
      chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
      cyc();
      chk("rr_last_b", last_b, (i % 2 == 1) ? 1 : 0);
      chk("rr_rd", rd, (i % 2 == 1) ? 2 : 1);
      chk("rr_wdata", wdata, (i % 2 == 1) ? 32'h2000 + i / 2 : 32'h1000 + i / 2);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    chk("rr_commits", ncommit - c0, 4);

    // Same destination, A then B; B's data survives
    a_valid = 1'b1; a_rd = 3'd5; a_wdata = 16'h00AA;
    b_valid = 1'b1; b_rd = 3'd5; b_wdata = 16'h00BB;
    #1;
    chk("same_rd_a_ready", a_ready, 1);
    chk("same_rd_b_ready", b_ready, 0);
    cyc();
    a_valid = 1'b0;
    #1;
    chk("same_rd_b_ready2", b_ready, 1);
    chk("same_rd_stage_a", wdata, 16'h00AA);
    cyc();
    b_valid = 1'b0;
    chk("same_rd_stage_b", wdata, 16'h00BB);
    chk("same_rd_rf_first", rf[5], 16'h00AA);
    cyc();
    chk("same_rd_rf_final", rf[5], 16'h00BB);
    chk("same_rd_empty", rd_we, 0);

    // Stall with gwe=0 while FULL; pointer now favours B
    a_valid = 1'b1; a_rd = 3'd6; a_wdata = 16'h6666;
    #1;
    chk("single_after_conf", a_ready, 1);
    cyc();
    a_rd = 3'd7; a_wdata = 16'h7777;
    b_valid = 1'b1; b_rd = 3'd1; b_wdata = 16'h0B0B;
    gwe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_a_ready", a_ready, 0);
      chk("stall_b_ready", b_ready, 0);
      cyc();
      chk("stall_rd", rd, 6);
      chk("stall_wdata", wdata, 16'h6666);
      chk("stall_we", rd_we, 1);
      chk("stall_last_b", last_b, 0);
    end
    chk("stall_no_commit", rf[6], 0);
    gwe = 1'b1;
    #1;
    chk("resume_b_ready", b_ready, 1);
    chk("resume_a_ready", a_ready, 0);
    cyc();
    b_valid = 1'b0;
    chk("resume_commit", rf[6], 16'h6666);
    chk("resume_rd", rd, 1);
    chk("resume_last_b", last_b, 1);
    #1;
    chk("held_a_ready", a_ready, 1);
    cyc();
    a_valid = 1'b0;
    chk("held_a_rd", rd, 7);
    chk("held_a_wdata", wdata, 16'h7777);

    // Asynchronous reset while FULL discards the entry
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_we", rd_we, 0);
    chk("async_rst_rd", rd, 0);
    chk("async_rst_wdata", wdata, 0);
    chk("async_rst_last_b", last_b, 0);
    cyc();
    cyc();
    rst = 1'b0;
    chk("async_rst_discard", rf[7], 0);

    // Forwarding lookup
    a_valid = 1'b1; a_rd = 3'd2; a_wdata = 16'hBEEF;
    rs = 3'd2; rt = 3'd4;
    cyc();
    a_valid = 1'b0;
    #1;
`ifdef LC4_WB_FWD_EN
    chk("fwd_rs_hit", rs_hit, 1);
    chk("fwd_rs_data", rs_fwd, 16'hBEEF);
    chk("fwd_rt_hit", rt_hit, 0);
    chk("fwd_rt_data", rt_fwd, 16'hBEEF);
`else
    chk("fwd_rs_hit", rs_hit, 0);
    chk("fwd_rs_data", rs_fwd, 0);
    chk("fwd_rt_hit", rt_hit, 0);
    chk("fwd_rt_data", rt_fwd, 0);
`endif
    chk("fwd_stage_we", rd_we, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
